// File: rtl/seg_pio_irq.sv
// seg_pio_irq: Avalon-MM slave driving NDIGIT active-low seven-segment digits
// and sampling NIN switch/key inputs. Inputs are synchronised, debounced per
// bit, and debounced edges are latched into a write-1-to-clear register that
// raises a maskable level interrupt.
//
// Register map (word addresses):
//   0 HEX     RW   byte i bits[6:0] = segment pattern of digit i
//   1 DATA    RO   debounced inputs
//   2 MASK    RW   interrupt enables
//   3 EDGECAP W1C  captured debounced edges
module seg_pio_irq #(
  parameter int NDIGIT    = 4,   // 1..4
  parameter int NIN       = 4,   // 1..32
  parameter int DEBOUNCE  = 16,  // 0 bypasses the debouncer
  parameter int EDGE_MODE = 0    // 0 rising, 1 falling, 2 both
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  write,
  input  logic                  read,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic                  irq,
  input  logic [NIN-1:0]        SW,
  output logic [7*NDIGIT-1:0]   nHEX
);

  localparam logic [1:0] ADDR_HEX     = 2'd0;
  localparam logic [1:0] ADDR_DATA    = 2'd1;
  localparam logic [1:0] ADDR_MASK    = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  // Register state and next-state values
  logic [7*NDIGIT-1:0] hex_reg;
  logic [7*NDIGIT-1:0] hex_next;
  logic [NIN-1:0]      mask_reg;
  logic [NIN-1:0]      mask_next;
  logic [NIN-1:0]      edgecap_reg;
  logic [NIN-1:0]      edgecap_next;

  // Input path: two synchroniser stages, then the debounced value
  logic [NIN-1:0]      s1_reg;
  logic [NIN-1:0]      s2_reg;
  logic [NIN-1:0]      db_reg;
  logic [NIN-1:0]      db_next;

  // Edge qualification and clear requests
  logic [NIN-1:0]      edge_set;
  logic [NIN-1:0]      w1c_bits;

  // Register read view of HEX (bit 7 of each byte and absent digits read 0)
  logic [31:0]         hex_read;

  // Bus write decode
  logic                wr_hex;
  logic                wr_mask;
  logic                wr_edgecap;

  // Not every writedata bit lands in a register (bit 7 of each byte, unused
  // digit bytes, mask bits above NIN); fold them into a sink so nothing dangles.
  logic                unused_wdata;

  assign unused_wdata = ^writedata;

  assign wr_hex     = write && (address == ADDR_HEX);
  assign wr_mask    = write && (address == ADDR_MASK);
  assign wr_edgecap = write && (address == ADDR_EDGECAP);

  // Per-digit segment pattern: only bits[6:0] of each byte are stored.
  genvar gi;
  generate
    for (gi = 0; gi < NDIGIT; gi++) begin : g_hex_wr
      assign hex_next[7*gi +: 7] = wr_hex ? writedata[8*gi +: 7] : hex_reg[7*gi +: 7];
    end

    for (gi = 0; gi < 4; gi++) begin : g_hex_rd
      if (gi < NDIGIT) begin : g_present
        assign hex_read[8*gi +: 8] = {1'b0, hex_reg[7*gi +: 7]};
      end else begin : g_absent
        assign hex_read[8*gi +: 8] = 8'h00;
      end
    end
  endgenerate

  assign mask_next = wr_mask ? writedata[NIN-1:0] : mask_reg;
  assign w1c_bits  = wr_edgecap ? writedata[NIN-1:0] : '0;

  // Per-bit debouncer: db follows s2 only after s2 has disagreed with db for
  // DEBOUNCE consecutive edges; any agreement restarts the count.
  generate
    for (gi = 0; gi < NIN; gi++) begin : g_debounce
      if (DEBOUNCE == 0) begin : g_bypass
        assign db_next[gi] = s2_reg[gi];
      end else begin : g_count
        localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
        localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

        logic [CW-1:0] cnt_reg;
        logic [CW-1:0] cnt_next;
        logic          db_bit_next;

        // Stability counter and debounced-bit update decision
        always_comb begin
          cnt_next    = cnt_reg;
          db_bit_next = db_reg[gi];
          if (s2_reg[gi] == db_reg[gi]) begin
            cnt_next = '0;
          end else if (cnt_reg == CNT_MAX) begin
            db_bit_next = s2_reg[gi];
            cnt_next    = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end

        // Stability counter register
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_next;
          end
        end

        assign db_next[gi] = db_bit_next;
      end
    end
  endgenerate

  // Which debounced transitions count as an event
  generate
    if (EDGE_MODE == 0) begin : g_edge_rise
      assign edge_set = db_next & ~db_reg;
    end else if (EDGE_MODE == 1) begin : g_edge_fall
      assign edge_set = ~db_next & db_reg;
    end else begin : g_edge_both
      assign edge_set = db_next ^ db_reg;
    end
  endgenerate

  // A new edge beats a simultaneous clear of the same bit.
  assign edgecap_next = (edgecap_reg & ~w1c_bits) | edge_set;

  // All architectural state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_reg      <= '0;
      s2_reg      <= '0;
      db_reg      <= '0;
      hex_reg     <= '1;
      mask_reg    <= '0;
      edgecap_reg <= '0;
    end else begin
      s1_reg      <= SW;
      s2_reg      <= s1_reg;
      db_reg      <= db_next;
      hex_reg     <= hex_next;
      mask_reg    <= mask_next;
      edgecap_reg <= edgecap_next;
    end
  end

  // Interrupt is a pure function of stored state, never of the bus or SW.
  assign irq  = |(edgecap_reg & mask_reg);
  assign nHEX = hex_reg;

  // Zero-wait-state read mux; shows pre-write contents during a write.
  always_comb begin
    readdata = '0;
    if (read && reset_n) begin
      unique case (address)
        ADDR_HEX:     readdata = hex_read;
        ADDR_DATA:    readdata = 32'(db_reg);
        ADDR_MASK:    readdata = 32'(mask_reg);
        ADDR_EDGECAP: readdata = 32'(edgecap_reg);
        default:      readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_pio_irq.sv
// Directed bench for seg_pio_irq. Instance a: DEBOUNCE=4, rising-edge capture.
// Instance b: debouncer bypassed, both-edge capture.
module tb_seg_pio_irq;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic [31:0] writedata;
  logic        write_a, read_a, write_b, read_b;
  logic [31:0] readdata_a, readdata_b;
  logic        irq_a, irq_b;
  logic [3:0]  sw_a, sw_b;
  logic [27:0] nhex_a, nhex_b;

  int checks = 0;
  int errors = 0;

  seg_pio_irq #(.NDIGIT(4), .NIN(4), .DEBOUNCE(4), .EDGE_MODE(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .write(write_a),
    .read(read_a), .writedata(writedata), .readdata(readdata_a),
    .irq(irq_a), .SW(sw_a), .nHEX(nhex_a)
  );

  seg_pio_irq #(.NDIGIT(4), .NIN(4), .DEBOUNCE(0), .EDGE_MODE(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .write(write_b),
    .read(read_b), .writedata(writedata), .readdata(readdata_b),
    .irq(irq_b), .SW(sw_b), .nHEX(nhex_b)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input bit sel_b, input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    if (sel_b) write_b = 1'b1; else write_a = 1'b1;
    $display("WR dut_%s addr=%0d data=0x%08h", sel_b ? "b" : "a", a, d);
    tick();
    write_a = 1'b0;
    write_b = 1'b0;
  endtask

  task automatic rdchk(input bit sel_b, input logic [1:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] d;
    address = a;
    if (sel_b) read_b = 1'b1; else read_a = 1'b1;
    #1;
    d = sel_b ? readdata_b : readdata_a;
    $display("RD dut_%s addr=%0d data=0x%08h", sel_b ? "b" : "a", a, d);
    read_a = 1'b0;
    read_b = 1'b0;
    #1;
    chk(tag, d, exp);
  endtask

  initial begin
    reset_n = 1'b0;
    address = 2'd0; writedata = '0;
    write_a = 1'b0; read_a = 1'b0; write_b = 1'b0; read_b = 1'b0;
    sw_a = 4'h0; sw_b = 4'h0;
    tick(); tick(); tick();
    reset_n = 1'b1;
    tick();

    // HEX write with bit 7 set in every byte
    wr(0, 2'd0, 32'h92B4D6F8);
    chk("nhex_d0", 32'(nhex_a[6:0]),   32'h78);
    chk("nhex_d1", 32'(nhex_a[13:7]),  32'h56);
    chk("nhex_d2", 32'(nhex_a[20:14]), 32'h34);
    chk("nhex_d3", 32'(nhex_a[27:21]), 32'h12);
    rdchk(0, 2'd0, 32'h12345678, "hex_readback");
    address = 2'd0; read_a = 1'b0; #1;
    chk("read_low_zero", readdata_a, 32'h0);
    wr(0, 2'd2, 32'hFFFFFFFF);
    rdchk(0, 2'd2, 32'h0000000F, "mask_upper_zero");
    wr(0, 2'd1, 32'h0000000F);
    rdchk(0, 2'd1, 32'h0, "data_write_ignored");

    // Asynchronous reset mid-cycle
    #3 reset_n = 1'b0;
    #1;
    chk("rst_nhex", 32'(nhex_a), 32'h0FFFFFFF);
    chk("rst_irq", 32'(irq_a), 32'h0);
    address = 2'd0; read_a = 1'b1; #1;
    chk("rst_readdata", readdata_a, 32'h0);
    read_a = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    rdchk(0, 2'd0, 32'h7F7F7F7F, "rst_hex");
    rdchk(0, 2'd1, 32'h0, "rst_data");
    rdchk(0, 2'd2, 32'h0, "rst_mask");
    rdchk(0, 2'd3, 32'h0, "rst_edgecap");

    // Pulse of 3 samples is filtered out
    sw_a = 4'h1;
    tick(); tick(); tick();
    sw_a = 4'h0;
    repeat (8) tick();
    rdchk(0, 2'd1, 32'h0, "short_pulse_data");
    rdchk(0, 2'd3, 32'h0, "short_pulse_edgecap");

    // Held input: DATA[0] rises after edge k+5, irq follows with mask set
    wr(0, 2'd2, 32'h1);
    sw_a = 4'h1;
    repeat (5) tick();
    rdchk(0, 2'd1, 32'h0, "db_k4_data");
    chk("db_k4_irq", 32'(irq_a), 32'h0);
    tick();
    rdchk(0, 2'd1, 32'h1, "db_k5_data");
    rdchk(0, 2'd3, 32'h1, "db_k5_edgecap");
    chk("db_k5_irq", 32'(irq_a), 32'h1);

    // W1C drops irq; falling edge captures nothing in rising mode
    wr(0, 2'd3, 32'h1);
    chk("w1c_irq", 32'(irq_a), 32'h0);
    rdchk(0, 2'd3, 32'h0, "w1c_edgecap");
    sw_a = 4'h0;
    repeat (7) tick();
    rdchk(0, 2'd1, 32'h0, "fall_data");
    rdchk(0, 2'd3, 32'h0, "fall_edgecap");
    chk("fall_irq", 32'(irq_a), 32'h0);

    // Clear on the same edge the debounced bit rises: set wins
    sw_a = 4'h1;
    repeat (5) tick();
    wr(0, 2'd3, 32'h1);
    rdchk(0, 2'd3, 32'h1, "collide_edgecap");
    rdchk(0, 2'd3, 32'h1, "read_no_clear");
    rdchk(0, 2'd1, 32'h1, "collide_data");
    chk("collide_irq", 32'(irq_a), 32'h1);
    wr(0, 2'd3, 32'h1);
    rdchk(0, 2'd3, 32'h0, "collide_cleared");

    // Read and write of MASK in the same cycle shows the old value
    address = 2'd2; writedata = 32'h3; write_a = 1'b1; read_a = 1'b1;
    #1;
    chk("rw_same_cycle", readdata_a, 32'h1);
    tick();
    write_a = 1'b0; read_a = 1'b0;
    rdchk(0, 2'd2, 32'h3, "rw_after");

    // Instance b: bypassed debouncer, both edges captured
    sw_b = 4'h2;
    tick(); tick();
    rdchk(1, 2'd1, 32'h0, "b_k1_data");
    tick();
    rdchk(1, 2'd1, 32'h2, "b_rise_data");
    rdchk(1, 2'd3, 32'h2, "b_rise_edgecap");
    chk("b_rise_irq_masked", 32'(irq_b), 32'h0);
    wr(1, 2'd3, 32'h2);
    rdchk(1, 2'd3, 32'h0, "b_clear");
    repeat (6) tick();
    sw_b = 4'h0;
    tick(); tick(); tick();
    rdchk(1, 2'd1, 32'h0, "b_fall_data");
    rdchk(1, 2'd3, 32'h2, "b_fall_edgecap");
    chk("b_fall_irq_masked", 32'(irq_b), 32'h0);
    wr(1, 2'd3, 32'h1);
    rdchk(1, 2'd3, 32'h2, "b_w1c_other_bit");
    wr(1, 2'd2, 32'h2);
    chk("b_mask_irq", 32'(irq_b), 32'h1);
    wr(1, 2'd3, 32'h2);
    chk("b_w1c_irq", 32'(irq_b), 32'h0);
    rdchk(1, 2'd3, 32'h0, "b_final_edgecap");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_pio_irq.md
Name: seg_pio_irq

Overview:
- Parametrised successor to the single-digit seven-segment/switch PIO.
- An Avalon-MM slave in the Nios II Qsys system that drives NDIGIT active-low seven-segment digits and samples NIN switch/key inputs.
- Inputs pass through a 2-FF synchroniser and a per-bit debouncer.
- Debounced edges are captured in a W1C register and raise a maskable interrupt.

Parameters:
- NDIGIT, 4, number of 7-seg digits driven (legal 1..4).
- NIN, 4, number of input bits (legal 1..32).
- DEBOUNCE, 16, stable-cycle count before a debounced bit changes; 0 = debouncer bypassed.
- EDGE_MODE, 0, capture edge: 0 rising, 1 falling, 2 both.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  register select.
- write  in  1  Avalon write strobe.
- read  in  1  Avalon read strobe.
- writedata  in  32  write data.
- readdata  out  32  read data.
- irq  out  1  interrupt, active high, level.
- SW  in  NIN  raw asynchronous inputs.
- nHEX  out  7*NDIGIT  segment drive, active low; digit i = nHEX[7i+6:7i].

Behaviour:
- Reset (reset_n low, asynchronous, any cycle including mid-debounce or mid-access):
  - nHEX all ones (blank).
  - Mask = 0; edge-capture = 0.
  - Sync FFs, debounced value and debounce counters = 0.
  - irq = 0; readdata = 0.
- Register map, writes take effect on the clk edge with write=1:
  - 0 HEX (RW): byte i bits[6:0] = digit i pattern; bit 7 of each byte and bytes >= NDIGIT are ignored on write and read back 0.
  - 1 DATA (RO): debounced inputs in bits[NIN-1:0]; writes ignored.
  - 2 MASK (RW): bits[NIN-1:0] interrupt enable; upper bits read 0.
  - 3 EDGECAP (R/W1C): bit n set on a qualifying debounced edge of input n; writing 1 clears, writing 0 no effect.
- Read: combinational, zero wait states.
  - readdata = 0 whenever read=0.
  - Otherwise readdata = the selected register in the same cycle.
  - A read does not clear EDGECAP.
- Synchroniser:
  - s1 <= SW, s2 <= s1 each edge.
  - A change on SW sampled at edge k appears on s2 at edge k+1.
- Debouncer, per bit, counter width clog2(DEBOUNCE) minimum 1:
  - If s2 == db: cnt <= 0.
  - If s2 != db and cnt == DEBOUNCE-1: db <= s2, cnt <= 0.
  - Otherwise (s2 != db): cnt <= cnt+1.
  - DEBOUNCE=0: db <= s2 every edge.
  - Resulting latency: db changes max(DEBOUNCE,1) edges after s2 changes, i.e. edge k+1+max(DEBOUNCE,1).
  - An s2 pulse shorter than DEBOUNCE cycles produces no db change.
- Edge detect: on the edge where db[n] updates, EDGECAP[n] is set if:
  - 0 → 1 and EDGE_MODE 0 or 2, or
  - 1 → 0 and EDGE_MODE 1 or 2.
- Same-cycle W1C and set of one bit: set wins (bit stays 1). W1C of other bits is unaffected.
- Repeated edges while a bit is already set: bit stays 1; no count is kept.
- irq = |(EDGECAP & MASK), from registers only (no combinational path from SW or the bus).
  - irq rises on the edge after the qualifying event or MASK write.
  - irq falls on the edge of the W1C or mask-clear.
- Simultaneous read and write to the same address: readdata shows the pre-write value.

Test Plan:
- Reset: hold reset_n=0 mid-run, release → nHEX=0x7F per digit (NDIGIT=4: 0xFFFFFFF), irq=0, reads of regs 0..3 return 0x7F7F7F7F/0/0/0.
- HEX write: write 0x12345678 to addr 0 → nHEX digit0=0x78, digit1=0x56, digit2=0x34, digit3=0x12; readback addr 0 = 0x12345678 with bit7s cleared (0x12345678 & 0x7F7F7F7F). A read with read=0 returns 0.
- Debounce (DEBOUNCE=4): SW[0] high for 3 cycles then low → DATA stays 0, EDGECAP 0. SW[0] held high, sampled at edge k → DATA[0]=1 after edge k+5, EDGECAP[0]=1.
- Interrupt (EDGE_MODE=0): MASK=0x1; SW[0] rising edge debounced → irq=1. Write EDGECAP 0x1 → irq=0 next edge. Falling edge sets nothing.
- Set/clear collision: W1C of bit 0 issued on the same edge db[0] rises → EDGECAP[0] remains 1.
- EDGE_MODE=2, DEBOUNCE=0: SW[1] toggles high, then low 10 cycles later → EDGECAP[1] set each time. MASK=0 keeps irq=0; setting MASK=0x2 raises irq on the next edge.
